// File: rtl/rom_arbiter.sv
// Two-master Wishbone arbiter sharing one ROM slave: grant held for a whole cyc,
// round-robin on ties, and a no-ack watchdog that answers with err instead of hanging.
module rom_arbiter #(
    parameter int unsigned AW      = 3,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DW-1:0]     m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DW-1:0]     m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    input  logic              s_ack_i,
    input  logic [DW-1:0]     s_dat_i,

    output logic [1:0]        gnt_o
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_M0   = 2'd1,
        S_M1   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_last, w_last_nxt;
    logic [7:0]        r_tcnt, w_tcnt_nxt;

    logic              w_busy;
    logic              w_sel_m1;
    logic              w_cyc;
    logic              w_stb;
    logic [DW/8-1:0]   w_sel;
    logic [AW-1:0]     w_adr;
    logic              w_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Mux of the granted master's request; an ack in the compare cycle beats the watchdog.
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_sel_m1  = (r_state == S_M1);
        w_cyc     = w_sel_m1 ? m1_cyc_i : m0_cyc_i;
        w_stb     = w_sel_m1 ? m1_stb_i : m0_stb_i;
        w_sel     = w_sel_m1 ? m1_sel_i : m0_sel_i;
        w_adr     = w_sel_m1 ? m1_adr_i : m0_adr_i;
        w_timeout = w_busy && w_stb && !s_ack_i && (r_tcnt == TMO);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_tcnt_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_state_nxt = r_last ? S_M0 : S_M1;
                else if (m0_cyc_i)
                    w_state_nxt = S_M0;
                else if (m1_cyc_i)
                    w_state_nxt = S_M1;
            end
            S_M0, S_M1: begin
                if (!w_cyc || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = w_sel_m1;
                end else if (w_stb && !s_ack_i) begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = w_busy && w_cyc && !w_timeout;
        s_stb_o  = w_busy && w_stb && !w_timeout;
        s_sel_o  = w_busy ? w_sel : '0;
        s_adr_o  = w_busy ? w_adr : '0;
        m0_ack_o = (r_state == S_M0) && s_ack_i;
        m1_ack_o = (r_state == S_M1) && s_ack_i;
        m0_err_o = (r_state == S_M0) && w_timeout;
        m1_err_o = (r_state == S_M1) && w_timeout;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        gnt_o    = {r_state == S_M1, r_state == S_M0};
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-master Wishbone arbiter that shares one single-port ROM slave (8x32 boot/microcode ROM, 1-cycle-registered ack) between the bexkat1 instruction-fetch port (master 0) and the data port (master 1). It holds the grant for a master's whole `cyc` so multi-beat fetches are not interleaved. It alternates grants round-robin under contention. A no-ack watchdog returns a bus error instead of hanging the CPU.

## Interface
Parameters:
- `AW`, 3: slave/master address width.
- `DW`, 32: data width.
- `TIMEOUT`, 15: max cycles with `s_stb_o` high and no `s_ack_i` before error; legal range 1..255.

Ports:
- `clk_i`  in  1  single clock, all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`  in  1 each  master 0 cycle/strobe.
- `m0_sel_i`  in  DW/8  master 0 byte selects.
- `m0_adr_i`  in  AW  master 0 address.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 ack/error.
- `m0_dat_o`  out  DW  read data to master 0.
- `m1_*`: identical set for master 1.
- `s_cyc_o`, `s_stb_o`  out  1 each  to ROM.
- `s_sel_o`  out  DW/8  to ROM.
- `s_adr_o`  out  AW  to ROM.
- `s_ack_i`  in  1  from ROM.
- `s_dat_i`  in  DW  from ROM.
- `gnt_o`  out  2  one-hot current grant, 00 when idle; debug/perf.

## Operation
- State machine has 3 states: `S_IDLE`, `S_M0`, `S_M1`. Registers: `state`, `last` (1 bit, last master served), `tcnt` (timeout counter, 8 bits).
- `S_IDLE`:
  - Only m0_cyc -> `S_M0`.
  - Only m1_cyc -> `S_M1`.
  - Both -> the master != `last`.
  - Neither -> stay.
  - Only `cyc` matters for the decision; `stb` is not required.
- `S_Mx`:
  - `s_cyc_o/s_stb_o/s_sel_o/s_adr_o` = master x inputs, combinationally.
  - `mx_ack_o = s_ack_i`.
  - The other master's ack/err = 0.
  - Stay while `mx_cyc_i` is high.
  - When `mx_cyc_i` is low -> `S_IDLE`, `last <= x`.
- In `S_IDLE` all `s_*` outputs are 0. `s_adr_o`/`s_sel_o` are 0 to keep traces clean.
- `m0_dat_o = m1_dat_o = s_dat_i` always. Masters qualify the data with their own ack.
- Watchdog:
  - In `S_Mx`, `tcnt` increments each cycle `s_stb_o & ~s_ack_i`.
  - It clears on `s_ack_i`, on `~s_stb_o`, and in `S_IDLE`.
  - When `tcnt == TIMEOUT` (combinational compare) and still no ack:
    - `mx_err_o = 1` for that cycle.
    - `s_cyc_o`/`s_stb_o` are forced 0 that cycle.
    - Next state is `S_IDLE`, `last <= x`, `tcnt <= 0`.
  - `s_ack_i` in the same cycle as the compare wins: ack, no err.
- `mx_ack_o` and `mx_err_o` are never both high. The non-granted master never sees ack or err.
- `gnt_o` = {state==S_M1, state==S_M0}.

## Timing
- Reset values:
  - `state=S_IDLE`, `last=1` (so m0 wins the first tie), `tcnt=0`.
  - All `s_*` outputs 0, all ack/err outputs 0, `gnt_o=00`.
- Reset asserted mid-transaction aborts immediately: outputs go to reset values asynchronously, and no ack/err is delivered.
- Arbitration latency is 1 cycle. A master raises `cyc/stb` in cycle N (from idle); the grant and `s_stb_o` appear in N+1. With the ROM's registered ack, `mx_ack_o` arrives in N+2.
- Ack passthrough has zero added latency. Back-to-back beats within one `cyc` are limited only by the slave (ROM: ack every 2nd cycle with `stb` held).
- Switchover always passes through one `S_IDLE` cycle. Master x drops `cyc` in cycle N; `S_IDLE` in N+1; the other master is granted in N+2.
- A master dropping `cyc` while the slave acks in the same cycle: the ack is still routed to it that cycle.
- Worst-case wait for the losing master = winner's full `cyc` + 2 cycles, or TIMEOUT + 2 if the winner hangs.

## Test plan
- Single master: m0 reads adr 3 from ROM preloaded with `mem[3]=32'hDEADBEEF` -> `gnt_o=01` at N+1, `m0_ack_o` at N+2 with `m0_dat_o=32'hDEADBEEF`; `m1_ack_o` stays 0.
- Simultaneous request after reset: m0 and m1 both raise `cyc` in the same cycle -> m0 granted first. After m0 drops `cyc`: `S_IDLE` for 1 cycle, then `gnt_o=10`. Repeat the tie -> m0 next (alternation verified over 4 rounds).
- Locked burst: m1 holds `cyc` for 4 beats (adr 0..3) while m0 requests continuously -> m0 is never granted until m1's `cyc` falls. m1 receives 4 acks with `mem[0..3]`.
- Timeout: slave model never acks, `TIMEOUT=15` -> `m0_err_o` pulses exactly once, 15 cycles after `s_stb_o` rises, with `s_stb_o=0` that cycle. Next cycle: `S_IDLE`, `tcnt=0`.
- Ack on the timeout boundary: slave acks exactly when `tcnt==TIMEOUT` -> ack delivered, no err, grant retained.
- Async reset mid-beat: assert `rst_i` between clock edges while `s_stb_o=1` -> all outputs 0 immediately. After release, a tie again goes to m0.
